// File: rtl/uart_rx_byte_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_byte_pkg
//   Shared definitions for the UART byte receiver: frame width, line idle
//   level and the receiver FSM state encoding.
//   The PARITY encoding is always reserved. The state is only reachable when
//   the design is built with UART_RX_PARITY_EN defined.
// ---------------------------------------------------------------------------
package uart_rx_byte_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_byte_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//   Generic n-flop synchroniser for bringing an asynchronous single-bit
//   signal into the i_clk domain. The reset value is programmable so that
//   an idle-high serial line does not look like a start bit out of reset.
// Ports
//   i_clk    in   system clock
//   i_rst_n  in   asynchronous reset, active low (flops preset to RESET_VAL)
//   i_d      in   asynchronous input
//   o_q      out  synchronised output, STAGES cycles of latency
// ---------------------------------------------------------------------------
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   Serial front end of the calculator. Receives 8N1 UART frames (optionally
//   with an even parity bit) on i_rx and presents each good byte on o_data
//   with a one-cycle o_valid strobe. Every bit is sampled at its centre by a
//   down-counter that is loaded with half a bit period on the start edge and
//   with a full bit period after that.
// Configuration
//   UART_RX_PARITY_EN  when defined, a parity bit follows the data bits and
//                      even parity is checked; otherwise the frame is 10 bits
//                      and o_parity_err is constant 0.
// Ports
//   i_clk         in   system clock
//   i_rst_n       in   asynchronous reset, active low
//   i_rx          in   raw UART line (asynchronous, idles high)
//   o_data        out  last good byte, held until the next good frame
//   o_valid       out  1-cycle strobe, o_data updated this cycle
//   o_frame_err   out  1-cycle strobe, stop bit sampled low
//   o_parity_err  out  1-cycle strobe with o_valid on a parity mismatch
//   o_busy        out  high from confirmed start bit until back in IDLE
//   o_state       out  current FSM state, for debug and checkers
// Handshake: o_valid has no ready. The consumer must take o_data in the
//   cycle o_valid is high. o_data stays stable until the next o_valid.
// ---------------------------------------------------------------------------
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_parity_err,
  output logic        o_busy,
  output uart_state_e o_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  logic rx_s;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bit_q, parity_bit_d;
  logic                      parity_err_q, parity_err_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end

      // The start bit is re-checked at its centre. A low pulse shorter than
      // half a bit is treated as line noise.
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            busy_d    = 1'b1;
            cnt_d     = FULL_LOAD;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // LSB arrives first, so shifting right leaves bit 0 in shreg[0].
      ST_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          parity_bit_d = rx_s;
          cnt_d        = FULL_LOAD;
          state_d      = ST_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      // A bad stop bit is reported once, and the FSM then parks in BREAK.
      // This keeps a held-low line from being decoded as a stream of 0x00
      // frames.
      ST_STOP: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ^shreg_q ^ parity_bit_q;
`endif
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;
  assign o_state     = state_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed bench for uart_rx_byte with CLKS_PER_BIT=16 and SYNC_STAGES=2.
//   Frames are driven bit by bit from tasks. A negedge monitor collects the
//   received bytes and counts the strobes. Each test task compares what it
//   observed against the values it expects.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;
  import uart_rx_byte_pkg::*;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_rx;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_parity_err;
  logic        o_busy;
  uart_state_e o_state;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_valid   = 0;
  int n_ferr    = 0;
  int n_perr    = 0;
  int n_busy    = 0;
  int n_overlap = 0;
  int valid_cyc = 0;

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      got_q.push_back(o_data);
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
    end
    if (o_frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (o_parity_err === 1'b1) n_perr <= n_perr + 1;
    if (o_busy === 1'b1) n_busy <= n_busy + 1;
    if ((o_valid === 1'b1 && o_frame_err === 1'b1) ||
        (o_parity_err === 1'b1 && o_valid !== 1'b1))
      n_overlap <= n_overlap + 1;
  end

  int total = 0;
  int bad   = 0;

  // ---------------- driver tasks ----------------
  // Every driver task is entered and left 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (CPB) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored, parity disabled");
`endif
    drive_bit(stop_bit);
  endtask

  task automatic idle_clks(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Compares the collected bytes with the expected queue, then empties both.
  task automatic check_bytes(input string tag);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_count got=%0d want=%0d", tag, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s_byte got=%h want=%h", tag, g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", o_data); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
    total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b want=0", o_frame_err); end
    total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL rst_perr got=%b want=0", o_parity_err); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
    total++; if (o_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", o_state, ST_IDLE); end
  endtask

  // 155 = 9.5 bit periods (152) + 2 synchroniser flops + 1 output register.
  // With parity enabled, one more bit period is added.
  task automatic test_single_byte;
    int start_cyc, busy0, v0, lat, exp_lat;
    exp_lat = 155;
`ifdef UART_RX_PARITY_EN
    exp_lat = exp_lat + CPB;
`endif
    idle_clks(4);
    busy0 = n_busy; v0 = n_valid; start_cyc = cyc;
    exp_q.push_back(8'h35);
    send_frame(8'h35, 1'b1, 1'b0);
    idle_clks(8);
    lat = valid_cyc - start_cyc;
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL t1_nvalid got=%0d want=1", n_valid - v0); end
    total++; if (lat < exp_lat - 1 || lat > exp_lat + 1) begin bad++; $display("FAIL t1_latency got=%0d want=%0d", lat, exp_lat); end
    // busy is high from the centre of the start bit to the stop sample:
    // 9 bit periods (144 cycles) without parity.
    total++; if (n_busy - busy0 < exp_lat - 13 || n_busy - busy0 > exp_lat - 9) begin bad++; $display("FAIL t1_busy_cycles got=%0d want=%0d", n_busy - busy0, exp_lat - 11); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%b want=0", o_busy); end
    check_bytes("t1");
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h0D);
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h0D, 1'b1, 1'b0);
    idle_clks(8);
    total++; if (n_valid - v0 != 2) begin bad++; $display("FAIL t2_nvalid got=%0d want=2", n_valid - v0); end
    total++; if (o_data !== 8'h0D) begin bad++; $display("FAIL t2_data_hold got=%h want=0d", o_data); end
    check_bytes("t2");
  endtask

  task automatic test_glitch;
    int v0, f0, b0;
    idle_clks(4);
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    i_rx = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    idle_clks(3 * CPB);
    total++; if (n_valid != v0 || n_ferr != f0) begin bad++; $display("FAIL t3_strobe got=%0d want=0", (n_valid - v0) + (n_ferr - f0)); end
    total++; if (n_busy != b0) begin bad++; $display("FAIL t3_busy got=%0d want=0", n_busy - b0); end
    total++; if (o_state !== ST_IDLE) begin bad++; $display("FAIL t3_state got=%0d want=%0d", o_state, ST_IDLE); end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h2B, 1'b0, 1'b0);
    i_rx = 1'b0;
    repeat (40 * CPB) @(posedge i_clk);
    #1;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL t4_busy_break got=%b want=1", o_busy); end
    idle_clks(2 * CPB);
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL t4_nferr got=%0d want=1", n_ferr - f0); end
    total++; if (n_valid != v0) begin bad++; $display("FAIL t4_nvalid got=%0d want=0", n_valid - v0); end
    total++; if (o_data !== 8'h0D) begin bad++; $display("FAIL t4_data_kept got=%h want=0d", o_data); end
    total++; if (o_state !== ST_IDLE) begin bad++; $display("FAIL t4_state got=%0d want=%0d", o_state, ST_IDLE); end
    exp_q.push_back(8'h2D);
    send_frame(8'h2D, 1'b1, 1'b0);
    idle_clks(8);
    check_bytes("t4");
  endtask

  task automatic test_reset_midframe;
    int v0;
    logic [7:0] d;
    d  = 8'h39;
    v0 = n_valid;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    i_rx = d[4];
    repeat (CPB / 2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle_clks(3 * CPB);
    total++; if (n_valid != v0) begin bad++; $display("FAIL t5_nvalid got=%0d want=0", n_valid - v0); end
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL t5_data_rst got=%h want=00", o_data); end
    total++; if (o_state !== ST_IDLE) begin bad++; $display("FAIL t5_state got=%0d want=%0d", o_state, ST_IDLE); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t5_busy got=%b want=0", o_busy); end
    got_q.delete();
    exp_q.push_back(8'h30);
    send_frame(8'h30, 1'b1, 1'b0);
    idle_clks(8);
    check_bytes("t5");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b1);
    idle_clks(8);
    total++; if (n_perr - p0 != 1) begin bad++; $display("FAIL t6_perr_bad got=%0d want=1", n_perr - p0); end
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL t6_valid_bad got=%0d want=1", n_valid - v0); end
    v0 = n_valid; p0 = n_perr;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b0);
    idle_clks(8);
    total++; if (n_perr != p0) begin bad++; $display("FAIL t6_perr_good got=%0d want=0", n_perr - p0); end
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL t6_valid_good got=%0d want=1", n_valid - v0); end
    check_bytes("t6");
  endtask
`endif

  task automatic test_strobe_rules;
    int exp_perr;
    exp_perr = 0;
`ifdef UART_RX_PARITY_EN
    exp_perr = 1;
`endif
    total++; if (n_overlap != 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", n_overlap); end
    total++; if (n_perr != exp_perr) begin bad++; $display("FAIL perr_total got=%0d want=%0d", n_perr, exp_perr); end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_strobe_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
